// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request
// at a time and loads fetched words into the IF/ID register. Handles decode
// stall (via a one-word hold buffer) and branch redirect (with drop of the
// stale in-flight response).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_BOOT  | one idle cycle after reset, no request
// S_FETCH | imem_req high, waiting for / accepting imem_ack
// S_HOLD  | word fetched while decode stalled; parked until stall drops
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               PCSrc,
  input  logic [31:0]        branch_target,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instn,
  output logic [31:0]        pc_plus4,
  output logic               instn_valid,
  output logic [31:0]        fetch_pc
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nxt;
  logic [31:0]        r_instn;
  logic [31:0]        w_instn_nxt;
  logic [31:0]        r_pc4;
  logic [31:0]        w_pc4_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic               r_discard;
  logic               w_discard_nxt;
  logic [IMEM_AW-1:0] r_stale_addr;
  logic [IMEM_AW-1:0] w_stale_addr_nxt;
  logic [31:0]        r_hold_instn;
  logic [31:0]        w_hold_instn_nxt;
  logic [31:0]        r_hold_pc4;
  logic [31:0]        w_hold_pc4_nxt;

  logic [31:0]        w_pc_inc;
  logic [31:0]        w_target;
  logic [IMEM_AW-1:0] w_pc_waddr;

  assign w_pc_inc   = r_pc + 32'd4;
  // Masking (rather than slicing) keeps every target bit referenced.
  assign w_target   = branch_target & 32'hFFFF_FFFC;
  assign w_pc_waddr = r_pc[IMEM_AW+1:2];

  // While a stale request is still outstanding the pc already points at the
  // redirect target, so the old word address is replayed from r_stale_addr.
  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_discard ? r_stale_addr : w_pc_waddr;
  assign instn       = r_instn;
  assign pc_plus4    = r_pc4;
  assign instn_valid = r_valid;
  assign fetch_pc    = r_pc;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_PC;
      r_instn      <= '0;
      r_pc4        <= '0;
      r_valid      <= 1'b0;
      r_discard    <= 1'b0;
      r_stale_addr <= '0;
      r_hold_instn <= '0;
      r_hold_pc4   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_instn      <= w_instn_nxt;
      r_pc4        <= w_pc4_nxt;
      r_valid      <= w_valid_nxt;
      r_discard    <= w_discard_nxt;
      r_stale_addr <= w_stale_addr_nxt;
      r_hold_instn <= w_hold_instn_nxt;
      r_hold_pc4   <= w_hold_pc4_nxt;
    end
  end

  // Next-state and next-datapath decode; redirect is applied last so it wins.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_instn_nxt      = r_instn;
    w_pc4_nxt        = r_pc4;
    w_valid_nxt      = r_valid;
    w_discard_nxt    = r_discard;
    w_stale_addr_nxt = r_stale_addr;
    w_hold_instn_nxt = r_hold_instn;
    w_hold_pc4_nxt   = r_hold_pc4;

    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (r_discard) begin
            // stale response: drop it; decode sees a bubble unless stalled
            w_discard_nxt = 1'b0;
            if (!stall) w_valid_nxt = 1'b0;
          end else if (!stall) begin
            w_instn_nxt = imem_rdata;
            w_pc4_nxt   = w_pc_inc;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_inc;
          end else begin
            w_hold_instn_nxt = imem_rdata;
            w_hold_pc4_nxt   = w_pc_inc;
            w_pc_nxt         = w_pc_inc;
            w_state_nxt      = S_HOLD;
          end
        end else if (!stall) begin
          w_valid_nxt = 1'b0;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          w_instn_nxt = r_hold_instn;
          w_pc4_nxt   = r_hold_pc4;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase

    if (PCSrc) begin
      w_pc_nxt         = w_target;
      w_valid_nxt      = 1'b0;
      w_instn_nxt      = r_instn;
      w_pc4_nxt        = r_pc4;
      w_hold_instn_nxt = '0;
      w_hold_pc4_nxt   = '0;
      w_state_nxt      = S_FETCH;
      if (r_state == S_FETCH && !imem_ack) begin
        // request still in flight: its response must be thrown away
        w_discard_nxt = 1'b1;
        if (!r_discard) w_stale_addr_nxt = w_pc_waddr;
      end else begin
        w_discard_nxt = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage: a transaction-level fetch model predicts,
// per cycle, the request/PC/valid view and the stream of words decode must
// receive; a monitor on the falling edge pops and compares.
module tb_if_stage;

  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
  localparam int          AW          = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall;
  logic          PCSrc;
  logic [31:0]   branch_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic [31:0]   instn;
  logic [31:0]   pc_plus4;
  logic          instn_valid;
  logic [31:0]   fetch_pc;

  if_stage #(.RESET_PC(TB_RESET_PC), .IMEM_AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .PCSrc         (PCSrc),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instn         (instn),
    .pc_plus4      (pc_plus4),
    .instn_valid   (instn_valid),
    .fetch_pc      (fetch_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a, ~a, a ^ 8'h5A, 8'h3C};
  endfunction

  // instruction memory: word content is a function of its address
  assign imem_rdata = mem_word(imem_addr);

  typedef struct packed {
    logic          req;
    logic [AW-1:0] addr;
    logic [31:0]   pc;
    logic          valid;
  } ctl_t;

  typedef struct packed {
    logic [31:0] instn;
    logic [31:0] pc4;
  } dat_t;

  ctl_t ctl_q[$];
  dat_t dat_q[$];

  int n_total = 0;
  int n_pass  = 0;
  bit mon_en  = 1'b0;
  bit last_stall = 1'b1;
  dat_t last_d = '0;

  // reference model state
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_stale;
  logic [AW-1:0] m_stale_addr;
  dat_t        m_parked[$];
  bit          m_ifid_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_boot       = 1'b1;
    m_pc         = TB_RESET_PC;
    m_stale      = 1'b0;
    m_stale_addr = '0;
    m_parked.delete();
    m_ifid_valid = 1'b0;
    ctl_q.delete();
    dat_q.delete();
    last_stall   = 1'b1;
  endtask

  // Apply one cycle of random stimulus and advance the model across the
  // coming clock edge. Called just after a rising edge.
  task automatic drive(input int ack_pct, input int stall_pct, input int br_pct);
    ctl_t e;
    dat_t d;
    bit   acc;
    stall    = ($urandom_range(99) < stall_pct);
    PCSrc    = ($urandom_range(99) < br_pct);
    imem_ack = ($urandom_range(99) < ack_pct);
    if ($urandom_range(3) == 0) branch_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
    else branch_target = $urandom;

    e.req   = !m_boot && (m_parked.size() == 0);
    e.addr  = m_stale ? m_stale_addr : m_pc[AW+1:2];
    e.pc    = m_pc;
    e.valid = m_ifid_valid;
    ctl_q.push_back(e);
    acc = imem_ack && e.req;

    if (PCSrc) begin
      if (e.req && !acc) begin
        if (!m_stale) m_stale_addr = m_pc[AW+1:2];
        m_stale = 1'b1;
      end else begin
        m_stale = 1'b0;
      end
      m_parked.delete();
      m_pc         = branch_target & 32'hFFFF_FFFC;
      m_ifid_valid = 1'b0;
      m_boot       = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_parked.size() != 0) begin
      if (!stall) begin
        dat_q.push_back(m_parked.pop_front());
        m_ifid_valid = 1'b1;
      end
    end else if (acc && m_stale) begin
      m_stale = 1'b0;
      if (!stall) m_ifid_valid = 1'b0;
    end else if (acc) begin
      d.instn = mem_word(m_pc[AW+1:2]);
      d.pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      if (stall) m_parked.push_back(d);
      else begin
        dat_q.push_back(d);
        m_ifid_valid = 1'b1;
      end
    end else if (!stall) begin
      m_ifid_valid = 1'b0;
    end
  endtask

  task automatic run(input int n, input int ack_pct, input int stall_pct, input int br_pct);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      drive(ack_pct, stall_pct, br_pct);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_instn", instn, 32'h0);
    chk("rst_pc_plus4", pc_plus4, 32'h0);
    chk("rst_instn_valid", instn_valid, 1'b0);
    chk("rst_fetch_pc", fetch_pc, TB_RESET_PC);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    drive(100, 0, 0);
  endtask

  // monitor: per-cycle control view plus every word newly loaded into IF/ID
  always @(negedge clk) begin
    ctl_t e;
    dat_t d;
    if (mon_en) begin
      if (ctl_q.size() == 0) begin
        chk("ctl_q_underflow", 32'd0, 32'd1);
      end else begin
        e = ctl_q.pop_front();
        chk("imem_req", imem_req, e.req);
        if (e.req) chk("imem_addr", imem_addr, e.addr);
        chk("fetch_pc", fetch_pc, e.pc);
        chk("instn_valid", instn_valid, e.valid);
      end
      if (instn_valid && !last_stall) begin
        if (dat_q.size() == 0) begin
          chk("unexpected_word", instn, 32'hDEAD_0000);
        end else begin
          d = dat_q.pop_front();
          chk("instn", instn, d.instn);
          chk("pc_plus4", pc_plus4, d.pc4);
          last_d = d;
        end
      end else if (instn_valid) begin
        chk("instn_hold", instn, last_d.instn);
        chk("pc_plus4_hold", pc_plus4, last_d.pc4);
      end
      last_stall = stall;
    end
  end

  initial begin
    rst_n         = 1'b0;
    stall         = 1'b0;
    PCSrc         = 1'b0;
    branch_target = 32'h0;
    imem_ack      = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();

    release_reset();
    run(10, 100, 0, 0);
    run(30, 30, 0, 0);
    run(400, 50, 30, 10);
    run(400, 80, 50, 20);
    run(3, 0, 0, 0);

    // asynchronous reset in the middle of a pending request
    @(posedge clk);
    #3;
    mon_en   = 1'b0;
    imem_ack = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs();

    release_reset();
    run(10, 100, 0, 0);
    run(200, 60, 20, 15);
    run(4, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("words_outstanding", dat_q.size(), 32'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
